// File: rtl/pipeline_mem_arbiter_pkg.sv
// Shared encodings for the IF/MEM unified-memory arbiter: FSM states, owner codes
// and the grant-priority rule.
package pipeline_mem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    // Data is older in program order and normally wins; IF is forced once starved.
    function automatic logic grant_to_if(input logic if_req,
                                         input logic dm_req,
                                         input logic streak_full);
        return if_req && (!dm_req || streak_full);
    endfunction

endpackage

// File: rtl/pipeline_mem_arbiter.sv
// Arbitrates one single-port fixed-latency memory between instruction fetch and
// load/store, one access at a time, with fetch-flush and anti-starvation support.
module pipeline_mem_arbiter
    import pipeline_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int LAT_W = (MEM_LAT    > 1) ? $clog2(MEM_LAT + 1)    : 1;
    localparam int STK_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(STARVE_MAX);

    logic [1:0]        r_state;
    logic              r_owner;
    logic              r_kill;
    logic [LAT_W-1:0]  r_lat;
    logic [STK_W-1:0]  r_streak;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_cap;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;

    logic w_streak_full;
    logic w_grant_if;
    logic w_any_req;
    logic w_resp;
    logic w_if_valid;
    logic w_dm_valid;
    logic w_dm_load_done;

    assign w_streak_full  = (r_streak == STK_MAX);
    assign w_grant_if     = grant_to_if(if_req, dm_req, w_streak_full);
    assign w_any_req      = if_req || dm_req;
    assign w_resp         = (r_state == ST_RESP);
    // A flush arriving in the response cycle itself must still swallow the fetch.
    assign w_if_valid     = w_resp && (r_owner == OWN_IF) && !r_kill && !if_flush;
    assign w_dm_valid     = w_resp && (r_owner == OWN_DM);
    assign w_dm_load_done = w_dm_valid && !r_mem_we;

    assign if_valid  = w_if_valid;
    assign dm_valid  = w_dm_valid;
    assign if_rdata  = w_if_valid     ? r_cap : r_if_rdata;
    assign dm_rdata  = w_dm_load_done ? r_cap : r_dm_rdata;
    assign if_stall  = if_req && !w_if_valid;
    assign dm_stall  = dm_req && !w_dm_valid;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_IF;
            r_kill      <= 1'b0;
            r_lat       <= '0;
            r_streak    <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cap       <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_kill <= 1'b0;
                    if (w_any_req) begin
                        r_state     <= ST_ISSUE;
                        r_mem_req   <= 1'b1;
                        r_owner     <= w_grant_if ? OWN_IF : OWN_DM;
                        r_mem_addr  <= w_grant_if ? if_addr : dm_addr;
                        r_mem_we    <= w_grant_if ? 1'b0 : dm_we;
                        r_mem_wdata <= w_grant_if ? '0 : dm_wdata;
                        r_kill      <= w_grant_if && if_flush;
                        // Streak counts only data grants that made a waiting fetch wait longer.
                        if (w_grant_if || !if_req) begin
                            r_streak <= '0;
                        end else if (!w_streak_full) begin
                            r_streak <= r_streak + STK_W'(1);
                        end
                    end
                end
                ST_ISSUE: begin
                    r_mem_req <= 1'b0;
                    r_lat     <= '0;
                    r_state   <= ST_WAIT;
                    if ((r_owner == OWN_IF) && if_flush) begin
                        r_kill <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if ((r_owner == OWN_IF) && if_flush) begin
                        r_kill <= 1'b1;
                    end
                    if (r_lat == LAT_LAST) begin
                        r_cap   <= mem_rdata;
                        r_state <= ST_RESP;
                    end else begin
                        r_lat <= r_lat + LAT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (w_if_valid) begin
                        r_if_rdata <= r_cap;
                    end
                    if (w_dm_load_done) begin
                        r_dm_rdata <= r_cap;
                    end
                    r_kill  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
